dtw_core_ctrl: RTL and testbench

//  Upstream sequencer for dtw_core_datapath. Buffers one query squiggle via valid/ready,

---
 rtl/dtw_core_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dtw_core_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_core_ctrl.sv
// dtw_core_ctrl: upstream sequencer for dtw_core_datapath.
// Buffers one query squiggle (sq_valid/sq_ready), clears the core for one
// cycle, then streams reference words from a sync-read memory in lockstep
// with the buffered squiggle. Waits for core_done, flushes the core pipeline
// for two cycles, and returns the captured min cost/position via res_valid/res_ready.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   sq_valid, sq_data, sq_ready   query sample input handshake
//   ref_len_cfg                   reference length, latched with first sample
//   ref_rd_en, ref_addr, ref_data reference memory read port (1-cycle latency)
//   core_*                        drive/observe the DTW core datapath
//   res_valid, res_ready,
//   res_minval, res_position      result handshake
//   busy                          high whenever not idle
// Optional feature macro DTW_MATCH_THRESH_EN adds input thresh (latched with
// the first sample) and output res_match = captured minval < thresh.
module dtw_core_ctrl #(
  parameter int width    = 16,
  parameter int SQG_SIZE = 10,
  parameter int REF_SIZE = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sq_valid,
  input  logic [width-1:0]    sq_data,
  output logic                sq_ready,
  input  logic [31:0]         ref_len_cfg,
  output logic                ref_rd_en,
  output logic [(REF_SIZE > 1 ? $clog2(REF_SIZE) : 1)-1:0] ref_addr,
  input  logic [width-1:0]    ref_data,
  output logic                core_rst,
  output logic                core_running,
  output logic [width-1:0]    core_squiggle,
  output logic [width-1:0]    core_rword,
  output logic [31:0]         core_ref_len,
  input  logic [width-1:0]    core_minval,
  input  logic [31:0]         core_position,
  input  logic                core_done,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [width-1:0]    res_minval,
  output logic [31:0]         res_position,
`ifdef DTW_MATCH_THRESH_EN
  input  logic [width-1:0]    thresh,
  output logic                res_match,
`endif
  output logic                busy
);
  localparam int ADDR_W = REF_SIZE > 1 ? $clog2(REF_SIZE) : 1;
  localparam int IW     = SQG_SIZE > 1 ? $clog2(SQG_SIZE) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, CLR, RUN, DRAIN, RESULT} state_t;
  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [31:0]       t_q, t_d, len_q, len_d;
  logic              drain_q, drain_d;
  logic              rd_q;
  logic [width-1:0]  res_min_q, res_min_d;
  logic [31:0]       res_pos_q, res_pos_d;
  logic [width-1:0]  sqbuf_q [SQG_SIZE];
  logic              store;
  logic              run;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    t_d       = t_q;
    len_d     = len_q;
    drain_d   = drain_q;
    res_min_d = res_min_q;
    res_pos_d = res_pos_q;
    store     = 1'b0;
    case (state_q)
      IDLE: if (sq_valid) begin
        store   = 1'b1;
        idx_d   = IW'(1);
        len_d   = ref_len_cfg > 32'(REF_SIZE) ? 32'(REF_SIZE) : ref_len_cfg;
        state_d = SQG_SIZE == 1 ? CLR : LOAD;
      end
      LOAD: if (sq_valid) begin
        store   = 1'b1;
        idx_d   = idx_q + IW'(1);
        state_d = idx_q == IW'(SQG_SIZE - 1) ? CLR : LOAD;
      end
      CLR: begin
        t_d     = '0;
        drain_d = 1'b0;
        if (len_q == '0) begin
          res_min_d = '1;
          res_pos_d = '0;
          state_d   = RESULT;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        t_d     = t_q + 32'd1;
        state_d = core_done ? DRAIN : RUN;
      end
      // Two flush cycles let the core's lastrow/min pipeline settle before capture.
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          res_min_d = core_minval;
          res_pos_d = core_position;
          state_d   = RESULT;
        end
      end
      RESULT: state_d = res_ready ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      t_q       <= '0;
      len_q     <= '0;
      drain_q   <= 1'b0;
      rd_q      <= 1'b0;
      res_min_q <= '1;
      res_pos_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      t_q       <= t_d;
      len_q     <= len_d;
      drain_q   <= drain_d;
      rd_q      <= ref_rd_en;
      res_min_q <= res_min_d;
      res_pos_q <= res_pos_d;
    end
  end
  always_ff @(posedge clk) begin
    if (store) sqbuf_q[state_q == IDLE ? IW'(0) : idx_q] <= sq_data;
  end
  assign run          = !rst && state_q == RUN;
  assign sq_ready     = !rst && (state_q == IDLE || state_q == LOAD);
  assign core_rst     = rst || state_q == CLR;
  assign core_running = !rst && (state_q == RUN || state_q == DRAIN);
  assign ref_rd_en    = run && t_q < len_q;
  assign ref_addr     = ref_rd_en ? ADDR_W'(t_q) : '0;
  // rd_q marks that last cycle issued a read, so ref_data holds word t-1; otherwise pad.
  assign core_rword    = run && t_q != '0 ? (rd_q ? ref_data : '1) : '0;
  assign core_squiggle = run && t_q != '0 && t_q <= 32'(SQG_SIZE) ? sqbuf_q[IW'(t_q - 32'd1)] : '0;
  assign core_ref_len  = len_q;
  assign res_valid     = !rst && state_q == RESULT;
  assign res_minval    = res_min_q;
  assign res_position  = res_pos_q;
  assign busy          = state_q != IDLE;
`ifdef DTW_MATCH_THRESH_EN
  logic [width-1:0] thr_q;
  logic             match_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q   <= '0;
      match_q <= 1'b0;
    end else begin
      if (state_q == IDLE && sq_valid) thr_q <= thresh;
      if (state_d == RESULT && state_q != RESULT) match_q <= res_min_d < thr_q;
    end
  end
  assign res_match = match_q;
`endif
endmodule

// File: tb/tb_dtw_core_ctrl.sv
// tb_dtw_core_ctrl: directed bench for dtw_core_ctrl with SQG_SIZE=4, REF_SIZE=16, identity reference memory.
module tb_dtw_core_ctrl;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic sq_valid = 1'b0, sq_ready;
  logic [W-1:0] sq_data = '0;
  logic [31:0] ref_len_cfg = '0;
  logic ref_rd_en;
  logic [3:0] ref_addr;
  logic [W-1:0] ref_data = '0;
  logic core_rst, core_running;
  logic [W-1:0] core_squiggle, core_rword;
  logic [31:0] core_ref_len;
  logic [W-1:0] core_minval = '0;
  logic [31:0] core_position = '0;
  logic core_done = 1'b0;
  logic res_valid, res_ready = 1'b0;
  logic [W-1:0] res_minval;
  logic [31:0] res_position;
  logic busy;
`ifdef DTW_MATCH_THRESH_EN
  logic [W-1:0] thresh = '0;
  logic res_match;
`endif
  int total = 0, bad = 0;

  dtw_core_ctrl #(.width(W), .SQG_SIZE(4), .REF_SIZE(16)) dut (
    .clk(clk), .rst(rst),
    .sq_valid(sq_valid), .sq_data(sq_data), .sq_ready(sq_ready),
    .ref_len_cfg(ref_len_cfg),
    .ref_rd_en(ref_rd_en), .ref_addr(ref_addr), .ref_data(ref_data),
    .core_rst(core_rst), .core_running(core_running),
    .core_squiggle(core_squiggle), .core_rword(core_rword), .core_ref_len(core_ref_len),
    .core_minval(core_minval), .core_position(core_position), .core_done(core_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_minval(res_minval), .res_position(res_position),
`ifdef DTW_MATCH_THRESH_EN
    .thresh(thresh), .res_match(res_match),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ref_rd_en) ref_data <= W'(ref_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Contiguous 4-sample query; ref_len_cfg is scrambled after the first sample.
  task automatic load(input logic [4*W-1:0] q, input logic [31:0] len);
    for (int i = 0; i < 4; i++) begin
      sq_valid = 1'b1;
      sq_data = q[i*W +: W];
      ref_len_cfg = i == 0 ? len : 32'h0000_0BAD;
      tick();
    end
    sq_valid = 1'b0;
  endtask

  // From RUN: done now, then two drain cycles; mv/pos are presented on the last one.
  task automatic finish_run(input logic [W-1:0] mv, input logic [31:0] pos);
    core_done = 1'b1;
    core_minval = ~mv;
    core_position = pos + 32'd100;
    tick();
    core_done = 1'b0;
    core_minval = mv ^ 16'h00FF;
    core_position = pos + 32'd200;
    tick();
    core_minval = mv;
    core_position = pos;
    tick();
    core_minval = 16'h5A5A;
    core_position = 32'hDEAD;
  endtask

  task automatic release_result;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    total += 8;
    if (core_rst !== 1'b1) begin bad++; $display("FAIL rst_core_rst got=%b exp=1", core_rst); end
    if (sq_ready !== 1'b0) begin bad++; $display("FAIL rst_sq_ready got=%b exp=0", sq_ready); end
    if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    if (ref_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en got=%b exp=0", ref_rd_en); end
    if (core_running !== 1'b0) begin bad++; $display("FAIL rst_running got=%b exp=0", core_running); end
    if (res_minval !== 16'hFFFF) begin bad++; $display("FAIL rst_minval got=%h exp=ffff", res_minval); end
    if (res_position !== 32'd0) begin bad++; $display("FAIL rst_position got=%h exp=0", res_position); end
    if (core_squiggle !== 16'd0 || core_rword !== 16'd0) begin bad++; $display("FAIL rst_core_data got=%h/%h exp=0/0", core_squiggle, core_rword); end
    rst = 1'b0;
    #1;
    total += 2;
    if (sq_ready !== 1'b1) begin bad++; $display("FAIL idle_sq_ready got=%b exp=1", sq_ready); end
    if (core_rst !== 1'b0) begin bad++; $display("FAIL idle_core_rst got=%b exp=0", core_rst); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL stray_res_ready busy=%b res_valid=%b exp=0/0", busy, res_valid); end
  endtask

  task automatic test_basic;
    load({16'd8, 16'd7, 16'd6, 16'd5}, 32'd8);
    total += 3;
    if (core_rst !== 1'b1) begin bad++; $display("FAIL clr_core_rst got=%b exp=1", core_rst); end
    if (sq_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL clr_flags sq_ready=%b busy=%b exp=0/1", sq_ready, busy); end
    if (core_ref_len !== 32'd8) begin bad++; $display("FAIL clr_ref_len got=%0d exp=8", core_ref_len); end
    tick();
    for (int t = 0; t < 12; t++) begin
      total += 4;
      if (core_running !== 1'b1 || core_rst !== 1'b0) begin bad++; $display("FAIL run_flags t=%0d running=%b core_rst=%b exp=1/0", t, core_running, core_rst); end
      if (ref_rd_en !== (t < 8)) begin bad++; $display("FAIL run_rd_en t=%0d got=%b exp=%b", t, ref_rd_en, t < 8); end
      if (ref_addr !== (t < 8 ? 4'(t) : 4'd0)) begin bad++; $display("FAIL run_addr t=%0d got=%0d", t, ref_addr); end
      if (core_squiggle !== (t >= 1 && t <= 4 ? 16'(t + 4) : 16'd0)) begin bad++; $display("FAIL run_squiggle t=%0d got=%0d exp=%0d", t, core_squiggle, (t >= 1 && t <= 4) ? t + 4 : 0); end
      if (t >= 1) begin
        total++;
        if (core_rword !== (t <= 8 ? 16'(t - 1) : 16'hFFFF)) begin bad++; $display("FAIL run_rword t=%0d got=%h", t, core_rword); end
      end
      if (t < 11) tick();
    end
    core_done = 1'b1;
    core_minval = 16'h1111;
    core_position = 32'd1;
    tick();
    core_done = 1'b0;
    core_minval = 16'h2222;
    core_position = 32'd2;
    total++;
    if (core_running !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL drain1 running=%b res_valid=%b exp=1/0", core_running, res_valid); end
    tick();
    core_minval = 16'h3333;
    core_position = 32'd3;
    total++;
    if (core_running !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL drain2 running=%b res_valid=%b exp=1/0", core_running, res_valid); end
    tick();
    core_minval = 16'h4444;
    core_position = 32'd4;
    total += 3;
    if (res_valid !== 1'b1 || core_running !== 1'b0) begin bad++; $display("FAIL result_flags res_valid=%b running=%b exp=1/0", res_valid, core_running); end
    if (res_minval !== 16'h3333) begin bad++; $display("FAIL result_minval got=%h exp=3333", res_minval); end
    if (res_position !== 32'd3) begin bad++; $display("FAIL result_position got=%0d exp=3", res_position); end
    release_result();
    total++;
    if (res_valid !== 1'b0 || sq_ready !== 1'b1) begin bad++; $display("FAIL after_result res_valid=%b sq_ready=%b exp=0/1", res_valid, sq_ready); end
  endtask

  task automatic test_toggle;
    for (int i = 0; i < 8; i++) begin
      sq_valid = i % 2 == 0;
      sq_data = i % 2 == 0 ? 16'(i / 2 + 1) : 16'hDEAD;
      ref_len_cfg = 32'd3;
      #1;
      total++;
      if (sq_ready !== (i < 7)) begin bad++; $display("FAIL toggle_ready i=%0d got=%b exp=%b", i, sq_ready, i < 7); end
      tick();
    end
    sq_valid = 1'b0;
    for (int t = 0; t < 6; t++) begin
      total++;
      if (core_squiggle !== (t >= 1 && t <= 4 ? 16'(t) : 16'd0)) begin bad++; $display("FAIL toggle_squiggle t=%0d got=%h exp=%0d", t, core_squiggle, (t >= 1 && t <= 4) ? t : 0); end
      if (t >= 1) begin
        total++;
        if (core_rword !== (t <= 3 ? 16'(t - 1) : 16'hFFFF)) begin bad++; $display("FAIL toggle_rword t=%0d got=%h", t, core_rword); end
      end
      if (t < 5) tick();
    end
    finish_run(16'h0005, 32'd9);
    total++;
    if (res_minval !== 16'h0005 || res_position !== 32'd9) begin bad++; $display("FAIL toggle_result got=%h/%0d exp=0005/9", res_minval, res_position); end
    release_result();
  endtask

  task automatic test_clamp;
    load({16'd4, 16'd3, 16'd2, 16'd1}, 32'd100);
    total++;
    if (core_ref_len !== 32'd16) begin bad++; $display("FAIL clamp_ref_len got=%0d exp=16", core_ref_len); end
    tick();
    for (int t = 0; t < 18; t++) begin
      total++;
      if (ref_rd_en !== (t < 16) || ref_addr !== (t < 16 ? 4'(t) : 4'd0)) begin bad++; $display("FAIL clamp_addr t=%0d got=%b/%0d", t, ref_rd_en, ref_addr); end
      if (t >= 1) begin
        total++;
        if (core_rword !== (t <= 16 ? 16'(t - 1) : 16'hFFFF)) begin bad++; $display("FAIL clamp_rword t=%0d got=%h", t, core_rword); end
      end
      if (t < 17) tick();
    end
    finish_run(16'h0007, 32'd17);
    total++;
    if (res_minval !== 16'h0007 || res_position !== 32'd17) begin bad++; $display("FAIL clamp_result got=%h/%0d exp=0007/17", res_minval, res_position); end
    release_result();
  endtask

  task automatic test_zero_len;
    load({16'd1, 16'd1, 16'd1, 16'd1}, 32'd0);
    total += 2;
    if (core_rst !== 1'b1) begin bad++; $display("FAIL zero_clr got=%b exp=1", core_rst); end
    if (core_ref_len !== 32'd0) begin bad++; $display("FAIL zero_ref_len got=%0d exp=0", core_ref_len); end
    tick();
    total += 3;
    if (res_valid !== 1'b1 || core_running !== 1'b0 || ref_rd_en !== 1'b0) begin bad++; $display("FAIL zero_flags res_valid=%b running=%b rd_en=%b exp=1/0/0", res_valid, core_running, ref_rd_en); end
    if (res_minval !== 16'hFFFF) begin bad++; $display("FAIL zero_minval got=%h exp=ffff", res_minval); end
    if (res_position !== 32'd0) begin bad++; $display("FAIL zero_position got=%0d exp=0", res_position); end
    release_result();
  endtask

  task automatic test_backpressure;
    load({16'd9, 16'd9, 16'd9, 16'd9}, 32'd2);
    tick();
    tick();
    tick();
    finish_run(16'h0042, 32'h77);
    for (int k = 0; k < 10; k++) begin
      core_minval = 16'(k);
      core_position = 32'(k);
      sq_valid = 1'b1;
      sq_data = 16'hBEEF;
      total++;
      if (res_valid !== 1'b1 || res_minval !== 16'h0042 || res_position !== 32'h77 || sq_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold k=%0d res_valid=%b minval=%h pos=%h sq_ready=%b exp=1/0042/77/0", k, res_valid, res_minval, res_position, sq_ready);
      end
      tick();
    end
    sq_valid = 1'b0;
    release_result();
    total++;
    if (res_valid !== 1'b0 || sq_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL hold_release res_valid=%b sq_ready=%b busy=%b exp=0/1/0", res_valid, sq_ready, busy); end
  endtask

  task automatic test_abort;
    load({16'd4, 16'd3, 16'd2, 16'd1}, 32'd8);
    tick();
    for (int t = 0; t < 5; t++) tick();
    total++;
    if (ref_addr !== 4'd5 || ref_rd_en !== 1'b1) begin bad++; $display("FAIL abort_pre addr=%0d rd_en=%b exp=5/1", ref_addr, ref_rd_en); end
    rst = 1'b1;
    #1;
    total++;
    if (core_rst !== 1'b1 || ref_rd_en !== 1'b0 || res_valid !== 1'b0 || core_running !== 1'b0) begin
      bad++;
      $display("FAIL abort_rst core_rst=%b rd_en=%b res_valid=%b running=%b exp=1/0/0/0", core_rst, ref_rd_en, res_valid, core_running);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || sq_ready !== 1'b1 || res_valid !== 1'b0 || ref_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle busy=%b sq_ready=%b res_valid=%b rd_en=%b exp=0/1/0/0", busy, sq_ready, res_valid, ref_rd_en);
    end
  endtask

`ifdef DTW_MATCH_THRESH_EN
  task automatic test_thresh;
    thresh = 16'd10;
    load({16'd1, 16'd2, 16'd3, 16'd4}, 32'd1);
    thresh = 16'd0;
    tick();
    tick();
    finish_run(16'd9, 32'd1);
    total++;
    if (res_match !== 1'b1) begin bad++; $display("FAIL thresh_below got=%b exp=1", res_match); end
    release_result();
    thresh = 16'd10;
    load({16'd1, 16'd2, 16'd3, 16'd4}, 32'd1);
    thresh = 16'hFFFF;
    tick();
    tick();
    finish_run(16'd10, 32'd1);
    total++;
    if (res_match !== 1'b0) begin bad++; $display("FAIL thresh_equal got=%b exp=0", res_match); end
    release_result();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_clamp();
    test_zero_len();
    test_backpressure();
    test_abort();
`ifdef DTW_MATCH_THRESH_EN
    test_thresh();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
